// File: rtl/sd_spi_pkg.sv
// Shared SD SPI definitions: command indices, R1 bit positions, frame layout
// and the CRC7 helpers used by both the card responder and the host controller.
package sd_spi_pkg;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD55  = 6'd55;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC     = 3;

  localparam int   FRAME_BITS = 48;
  localparam int   CRC_SPAN   = 40;
  localparam logic START_BIT  = 1'b0;
  localparam logic TX_BIT     = 1'b1;
  localparam logic END_BIT    = 1'b1;

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_NCR  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // One serial step of x^7 + x^3 + 1, message bit entering at the top.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] crc;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) crc = crc7_step(crc, data[i]);
    return crc;
  endfunction

endpackage

// File: rtl/sd_spi_responder_if.sv
// Card-side SPI pins plus the decoded-command sideband of the SD responder.
interface sd_spi_responder_if;
  import sd_spi_pkg::*;

  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic        cmd_strobe;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        crc_err;
  logic        card_ready;
  logic [1:0]  fsm_state;

  // SPI handshake: no valid/ready; the host owns sclk and cs, the card only
  // reacts to synchronised sclk edges while cs is low and always drives miso.
  modport slave (
    input  sclk, cs, mosi,
    output miso, cmd_strobe, cmd_index, cmd_arg, crc_err, card_ready, fsm_state
  );

  modport master (
    output sclk, cs, mosi,
    input  miso, cmd_strobe, cmd_index, cmd_arg, crc_err, card_ready, fsm_state
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one message bit per enabled cycle.
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic       clk_bus,
  input  logic       res,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk_bus or posedge res) begin
    if (res)      crc <= 7'd0;
    else if (clr) crc <= 7'd0;
    else if (en)  crc <= crc7_step(crc, din);
  end

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: oversamples the host's sclk, decodes 48-bit
// command frames and returns R1 responses while tracking the init handshake.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RESP_DELAY  = 1,
  parameter int BUSY_COUNT  = 2,
  parameter int CHECK_CRC   = 0
) (
  input  logic clk_bus,
  input  logic res,
  sd_spi_responder_if.slave bus
);

  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
  localparam logic [5:0] CRC_END  = 6'(CRC_SPAN);
  localparam logic [6:0] NCR_LAST = 7'(RESP_DELAY * 8 - 1);
  localparam logic [3:0] BUSY_TH  = 4'(BUSY_COUNT);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_prev;
  logic sclk_s, cs_s, mosi_s, rise, fall;

  always_ff @(posedge clk_bus or posedge res) begin
    if (res) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev;
  assign fall   = ~sclk_s & sclk_prev;

  logic [1:0]  state;
  logic [5:0]  bit_cnt;
  logic [45:0] shreg;
  logic [6:0]  tx_cnt;
  logic [7:0]  r1;
  logic        miso_q, strobe_q, crc_err_q, ready_q;
  logic [5:0]  index_q;
  logic [31:0] arg_q;
  logic        spi_mode, idle, app_cmd;
  logic [3:0]  acmd41_cnt, next_cnt;
  logic [6:0]  crc_val;

  // The start bit is never stored, so shreg holds frame bits 1..46 at decode.
  logic        tx_bit_ok, end_bit_ok, crc_ok;
  logic [5:0]  dec_index;
  logic [31:0] dec_arg;

  assign tx_bit_ok  = (shreg[45] == TX_BIT);
  assign end_bit_ok = (mosi_s == END_BIT);
  assign dec_index  = shreg[44:39];
  assign dec_arg    = shreg[38:7];
  assign crc_ok     = (crc_val == shreg[6:0]);
  assign next_cnt   = (acmd41_cnt == 4'hF) ? 4'hF : acmd41_cnt + 4'd1;

  sd_crc7 u_crc7 (
    .clk_bus (clk_bus),
    .res     (res),
    .clr     (state == ST_HUNT),
    .en      (rise && !cs_s && state == ST_CMD && bit_cnt < CRC_END),
    .din     (mosi_s),
    .crc     (crc_val)
  );

  always_ff @(posedge clk_bus or posedge res) begin
    if (res) begin
      state      <= ST_HUNT;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx_cnt     <= '0;
      r1         <= 8'hFF;
      miso_q     <= 1'b1;
      strobe_q   <= 1'b0;
      crc_err_q  <= 1'b0;
      ready_q    <= 1'b0;
      index_q    <= '0;
      arg_q      <= '0;
      spi_mode   <= 1'b0;
      idle       <= 1'b1;
      app_cmd    <= 1'b0;
      acmd41_cnt <= '0;
    end else begin
      strobe_q  <= 1'b0;
      crc_err_q <= 1'b0;
      if (cs_s) begin
        // Deselect overrides everything, including a coincident final rise.
        state  <= ST_HUNT;
        miso_q <= 1'b1;
      end else begin
        case (state)
          ST_HUNT: begin
            miso_q <= 1'b1;
            if (rise && mosi_s == START_BIT) begin
              state   <= ST_CMD;
              bit_cnt <= 6'd1;
              shreg   <= '0;
            end
          end
          ST_CMD: begin
            if (rise) begin
              if (bit_cnt != LAST_BIT) begin
                shreg   <= {shreg[44:0], mosi_s};
                bit_cnt <= bit_cnt + 6'd1;
              end else if (!tx_bit_ok || !end_bit_ok) begin
                state <= ST_HUNT;
              end else if (CHECK_CRC != 0 && !crc_ok) begin
                crc_err_q <= 1'b1;
                r1        <= (8'b1 << R1_CRC) | {7'b0, idle};
                state     <= ST_NCR;
                tx_cnt    <= '0;
              end else if (!spi_mode && dec_index != CMD0) begin
                state <= ST_HUNT;
              end else begin
                strobe_q <= 1'b1;
                index_q  <= dec_index;
                arg_q    <= dec_arg;
                app_cmd  <= 1'b0;
                state    <= ST_NCR;
                tx_cnt   <= '0;
                if (dec_index == CMD0) begin
                  spi_mode   <= 1'b1;
                  idle       <= 1'b1;
                  acmd41_cnt <= '0;
                  ready_q    <= 1'b0;
                  r1         <= 8'b1 << R1_IDLE;
                end else if (dec_index == CMD55) begin
                  app_cmd <= 1'b1;
                  r1      <= {7'b0, idle};
                end else if (dec_index == ACMD41 && app_cmd) begin
                  acmd41_cnt <= next_cnt;
                  if (next_cnt >= BUSY_TH) begin
                    idle    <= 1'b0;
                    ready_q <= 1'b1;
                    r1      <= 8'h00;
                  end else begin
                    r1 <= 8'b1 << R1_IDLE;
                  end
                end else begin
                  r1 <= (8'b1 << R1_ILLEGAL) | {7'b0, idle};
                end
              end
            end
          end
          ST_NCR: begin
            if (fall) begin
              miso_q <= 1'b1;
              if (tx_cnt == NCR_LAST) begin
                state  <= ST_RESP;
                tx_cnt <= '0;
              end else begin
                tx_cnt <= tx_cnt + 7'd1;
              end
            end
          end
          ST_RESP: begin
            if (fall && tx_cnt < 7'd8) begin
              miso_q <= r1[7];
              r1     <= {r1[6:0], 1'b1};
              tx_cnt <= tx_cnt + 7'd1;
            end else if (rise && tx_cnt == 7'd8) begin
              state  <= ST_HUNT;
              miso_q <= 1'b1;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign bus.miso       = miso_q;
  assign bus.cmd_strobe = strobe_q;
  assign bus.cmd_index  = index_q;
  assign bus.cmd_arg    = arg_q;
  assign bus.crc_err    = crc_err_q;
  assign bus.card_ready = ready_q;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for the SD SPI responder: host-side bit-banged SPI against
// two card instances (CRC checking off and on).
module tb_sd_spi_responder;
  import sd_spi_pkg::*;

  localparam logic [47:0] F_CMD0     = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD0_BAD = 48'h40_0000_0000_5F;
  localparam logic [47:0] F_CMD55    = 48'h77_0000_0000_65;
  localparam logic [47:0] F_ACMD41   = 48'h69_4000_0000_77;
  localparam logic [47:0] F_CMD8     = 48'h48_0000_01AA_87;

  logic clk_bus, res, sclk, mosi, cs_n, sel;
  logic miso_mux;
  int   checks, errors;
  int   strobe0, strobe1, crcerr0, crcerr1;
  logic ready_at_strobe0;
  logic [7:0] exp_q[$];

  sd_spi_responder_if if0 ();
  sd_spi_responder_if if1 ();

  assign if0.sclk = sclk;
  assign if0.mosi = mosi;
  assign if0.cs   = sel ? 1'b1 : cs_n;
  assign if1.sclk = sclk;
  assign if1.mosi = mosi;
  assign if1.cs   = sel ? cs_n : 1'b1;
  assign miso_mux = sel ? if1.miso : if0.miso;

  sd_spi_responder #(.SYNC_STAGES(2), .RESP_DELAY(1), .BUSY_COUNT(2), .CHECK_CRC(0)) u_dut0 (
    .clk_bus (clk_bus),
    .res     (res),
    .bus     (if0)
  );

  sd_spi_responder #(.SYNC_STAGES(2), .RESP_DELAY(1), .BUSY_COUNT(2), .CHECK_CRC(1)) u_dut1 (
    .clk_bus (clk_bus),
    .res     (res),
    .bus     (if1)
  );

  // Clock / reset
  initial clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  always @(negedge clk_bus) begin
    if (if0.cmd_strobe) begin
      strobe0++;
      ready_at_strobe0 = if0.card_ready;
    end
    if (if1.cmd_strobe) strobe1++;
    if (if0.crc_err) crcerr0++;
    if (if1.crc_err) crcerr1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk(tag, {24'b0, obs}, {24'b0, e});
  endtask

  // Driver tasks: mode 0, host samples miso just before each rise.
  task automatic bit_xfer(input logic b, output logic r);
    mosi = b;
    #60;
    r = miso_mux;
    sclk = 1'b1;
    #60;
    sclk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) bit_xfer(tx[i], rx[i]);
  endtask

  task automatic send_frame(input logic [47:0] f);
    logic r;
    cs_n = 1'b0;
    for (int i = 47; i >= 0; i--) bit_xfer(f[i], r);
  endtask

  task automatic read_resp(output logic [7:0] b0, output logic [7:0] b1);
    xfer_byte(8'hFF, b0);
    xfer_byte(8'hFF, b1);
  endtask

  task automatic read_idle(output logic [7:0] acc);
    logic [7:0] b;
    acc = 8'hFF;
    repeat (8) begin
      xfer_byte(8'hFF, b);
      acc &= b;
    end
  endtask

  task automatic deselect();
    mosi = 1'b1;
    #60 cs_n = 1'b1;
    #240;
  endtask

  initial begin
    logic [7:0] b0, b1, acc;
    logic r;
    int s0;
    checks = 0; errors = 0;
    strobe0 = 0; strobe1 = 0; crcerr0 = 0; crcerr1 = 0;
    ready_at_strobe0 = 1'b0;
    sclk = 1'b0; mosi = 1'b1; cs_n = 1'b1; sel = 1'b0; res = 1'b1;
    #43 res = 1'b0;
    #60;

    chk("rst_miso",   {31'b0, if0.miso}, 32'd1);
    chk("rst_strobe", {31'b0, if0.cmd_strobe}, 32'd0);
    chk("rst_crcerr", {31'b0, if0.crc_err}, 32'd0);
    chk("rst_index",  {26'b0, if0.cmd_index}, 32'd0);
    chk("rst_arg",    if0.cmd_arg, 32'd0);
    chk("rst_ready",  {31'b0, if0.card_ready}, 32'd0);
    chk("rst_state",  {30'b0, if0.fsm_state}, {30'b0, ST_HUNT});

    // CMD55 before CMD0: silently ignored
    send_frame(F_CMD55);
    read_idle(acc);
    chk("pre_cmd55_miso", {24'b0, acc}, 32'hFF);
    chk("pre_cmd55_strobe", strobe0, 0);
    deselect();

    // CMD0
    s0 = strobe0;
    send_frame(F_CMD0);
    read_resp(b0, b1);
    exp_q.push_back(8'hFF); chk_resp("cmd0_ncr", b0);
    exp_q.push_back(8'h01); chk_resp("cmd0_r1", b1);
    chk("cmd0_strobe", strobe0 - s0, 1);
    chk("cmd0_index", {26'b0, if0.cmd_index}, 32'd0);
    chk("cmd0_arg", if0.cmd_arg, 32'd0);
    deselect();

    // CMD8: illegal in this card, idle still set
    s0 = strobe0;
    send_frame(F_CMD8);
    read_resp(b0, b1);
    exp_q.push_back(8'hFF); chk_resp("cmd8_ncr", b0);
    exp_q.push_back(8'h05); chk_resp("cmd8_r1", b1);
    chk("cmd8_strobe", strobe0 - s0, 1);
    chk("cmd8_index", {26'b0, if0.cmd_index}, 32'd8);
    chk("cmd8_arg", if0.cmd_arg, 32'h0000_01AA);
    deselect();

    // Abort a CMD0 after 20 bits
    s0 = strobe0;
    cs_n = 1'b0;
    for (int i = 47; i >= 28; i--) bit_xfer(F_CMD0[i], r);
    mosi = 1'b1;
    cs_n = 1'b1;
    #240;
    chk("abort_state", {30'b0, if0.fsm_state}, {30'b0, ST_HUNT});
    cs_n = 1'b0;
    read_resp(b0, b1);
    chk("abort_miso", {24'b0, b0 & b1}, 32'hFF);
    chk("abort_strobe", strobe0 - s0, 0);
    chk("abort_index", {26'b0, if0.cmd_index}, 32'd8);
    deselect();
    send_frame(F_CMD0);
    read_resp(b0, b1);
    exp_q.push_back(8'h01); chk_resp("abort_cmd0_r1", b1);
    chk("abort_cmd0_strobe", strobe0 - s0, 1);
    deselect();

    // Init loop, BUSY_COUNT = 2
    send_frame(F_CMD55);
    read_resp(b0, b1);
    exp_q.push_back(8'h01); chk_resp("init_cmd55a_r1", b1);
    deselect();
    send_frame(F_ACMD41);
    read_resp(b0, b1);
    exp_q.push_back(8'h01); chk_resp("init_acmd41a_r1", b1);
    chk("init_acmd41a_ready", {31'b0, ready_at_strobe0}, 32'd0);
    chk("init_acmd41a_index", {26'b0, if0.cmd_index}, 32'd41);
    deselect();
    send_frame(F_CMD55);
    read_resp(b0, b1);
    exp_q.push_back(8'h01); chk_resp("init_cmd55b_r1", b1);
    deselect();
    send_frame(F_ACMD41);
    read_resp(b0, b1);
    exp_q.push_back(8'hFF); chk_resp("init_acmd41b_ncr", b0);
    exp_q.push_back(8'h00); chk_resp("init_acmd41b_r1", b1);
    chk("init_acmd41b_ready_strobe", {31'b0, ready_at_strobe0}, 32'd1);
    chk("init_acmd41b_arg", if0.cmd_arg, 32'h4000_0000);
    deselect();

    // Index 41 without a preceding CMD55 is illegal
    s0 = strobe0;
    send_frame(F_ACMD41);
    read_resp(b0, b1);
    exp_q.push_back(8'h04); chk_resp("bare41_r1", b1);
    chk("bare41_strobe", strobe0 - s0, 1);
    chk("bare41_ready", {31'b0, if0.card_ready}, 32'd1);
    deselect();

    // Reset while the 4th R1 bit of a CMD55 response (0x00) is on miso
    send_frame(F_CMD55);
    xfer_byte(8'hFF, b0);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
    #40;
    chk("mid_resp_miso", {31'b0, if0.miso}, 32'd0);
    chk("mid_resp_ready", {31'b0, if0.card_ready}, 32'd1);
    res = 1'b1;
    #1;
    chk("reset_resp_miso", {31'b0, if0.miso}, 32'd1);
    chk("reset_resp_ready", {31'b0, if0.card_ready}, 32'd0);
    chk("reset_resp_state", {30'b0, if0.fsm_state}, {30'b0, ST_HUNT});
    #19 res = 1'b0;
    deselect();
    s0 = strobe0;
    send_frame(F_CMD55);
    read_idle(acc);
    chk("post_reset_cmd55_miso", {24'b0, acc}, 32'hFF);
    chk("post_reset_cmd55_strobe", strobe0 - s0, 0);
    deselect();

    // CRC-checking instance
    sel = 1'b1;
    send_frame(F_CMD0_BAD);
    read_resp(b0, b1);
    exp_q.push_back(8'hFF); chk_resp("badcrc_ncr", b0);
    exp_q.push_back(8'h09); chk_resp("badcrc_r1", b1);
    chk("badcrc_crcerr", crcerr1, 1);
    chk("badcrc_strobe", strobe1, 0);
    deselect();
    send_frame(F_CMD55);
    read_idle(acc);
    chk("badcrc_still_native", {24'b0, acc}, 32'hFF);
    chk("badcrc_cmd55_strobe", strobe1, 0);
    deselect();
    send_frame(F_CMD0);
    read_resp(b0, b1);
    exp_q.push_back(8'h01); chk_resp("goodcrc_cmd0_r1", b1);
    chk("goodcrc_strobe", strobe1, 1);
    chk("goodcrc_crcerr", crcerr1, 1);
    deselect();
    chk("crc_off_no_crcerr", crcerr0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
